cmd_status_bridge: RTL and testbench

- Parametrised N-channel command/status bridge: arbitrates CHANNELS independent command ports onto one command/status bus.
- Tracks outstanding transactions in an in-order ID FIFO and routes each bus status response back to the originating channel.
- Sits between per-client command and status interfaces and a shared master-side bus interface.
- Successor to the single-channel pass-through connection: adds multi-channel arbitration, buffering and in-order response routing.

---
 rtl/cmd_status_bridge_if.sv | 51 +++++
 rtl/cmd_status_bridge.sv | 150 +++++++++++++++
 tb/tb_cmd_status_bridge.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_status_bridge_if.sv
// Bus bundle for cmd_status_bridge: per-channel command/status ports plus the shared bus side.
// The o_error_count member is present only when CMD_STATUS_BRIDGE_ERRCNT_EN is defined.
interface cmd_status_bridge_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CMD_WIDTH = 8,
  parameter int unsigned DEPTH     = 8
);
  logic [CHANNELS-1:0]           i_cmd_valid;
  logic [CHANNELS-1:0]           o_cmd_ready;
  logic [CHANNELS-1:0]           i_cmd_op;
  logic [CHANNELS*CMD_WIDTH-1:0] i_cmd_data;
  logic                          o_bus_cmd_valid;
  logic                          i_bus_cmd_ready;
  logic                          o_bus_cmd_op;
  logic [CMD_WIDTH-1:0]          o_bus_cmd_data;
  logic                          i_bus_status_valid;
  logic                          o_bus_status_ready;
  logic                          i_bus_status;
  logic [CHANNELS-1:0]           o_status_valid;
  logic [CHANNELS-1:0]           i_status_ready;
  logic                          o_status;
  logic [$clog2(DEPTH+1)-1:0]    o_outstanding;
  logic                          o_orphan;
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
  logic [15:0]                   o_error_count;
`endif

  // Bridge side
  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_data, i_bus_cmd_ready,
    input  i_bus_status_valid, i_bus_status, i_status_ready,
    output o_cmd_ready, o_bus_cmd_valid, o_bus_cmd_op, o_bus_cmd_data,
    output o_bus_status_ready, o_status_valid, o_status, o_outstanding,
    output o_orphan
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    , output o_error_count
`endif
  );

  // Client/bus environment side
  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_data, i_bus_cmd_ready,
    output i_bus_status_valid, i_bus_status, i_status_ready,
    input  o_cmd_ready, o_bus_cmd_valid, o_bus_cmd_op, o_bus_cmd_data,
    input  o_bus_status_ready, o_status_valid, o_status, o_outstanding,
    input  o_orphan
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    , input o_error_count
`endif
  );
endinterface

// File: rtl/cmd_status_bridge.sv
// N-channel round-robin command bridge with in-order status routing via an ID FIFO.
// Optional popped-error counter enabled by CMD_STATUS_BRIDGE_ERRCNT_EN.
module cmd_status_bridge #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CMD_WIDTH = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cmd_status_bridge_if.slave   io
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CH_W-1:0]      last_grant_q, last_grant_d;
  logic                 bus_valid_q, bus_valid_d;
  logic                 bus_op_q, bus_op_d;
  logic [CMD_WIDTH-1:0] bus_data_q, bus_data_d;
  logic [CH_W-1:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 orphan_q, orphan_d;

  logic                 found;
  logic [CH_W-1:0]      grant;
  logic                 sel_op;
  logic [CMD_WIDTH-1:0] sel_data;
  logic                 slot_free, fifo_full, fifo_empty, accept, push, pop;
  logic [CH_W-1:0]      head;
  int unsigned          idx;

  // Round-robin search beginning one past the last grant
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    sel_op   = 1'b0;
    sel_data = '0;
    idx      = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (32'(last_grant_q) + 1 + i) % CHANNELS;
      if (!found && io.i_cmd_valid[idx]) begin
        found    = 1'b1;
        grant    = CH_W'(idx);
        sel_op   = io.i_cmd_op[idx];
        sel_data = io.i_cmd_data[idx*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  // Full blocks new commands even if a pop happens this same cycle
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign slot_free  = !bus_valid_q || io.i_bus_cmd_ready;
  assign accept     = slot_free && !fifo_full && found;
  assign push       = accept;
  assign head       = fifo_q[rd_ptr_q];
  assign pop        = !fifo_empty && io.i_bus_status_valid && io.i_status_ready[head];

  always_comb begin
    io.o_cmd_ready = '0;
    if (accept) io.o_cmd_ready[grant] = 1'b1;
  end

  // Empty FIFO: accept and drop any stray status
  always_comb begin
    io.o_status_valid     = '0;
    io.o_bus_status_ready = 1'b1;
    if (!fifo_empty) begin
      io.o_status_valid[head] = io.i_bus_status_valid;
      io.o_bus_status_ready   = io.i_status_ready[head];
    end
  end

  assign io.o_status        = io.i_bus_status;
  assign io.o_bus_cmd_valid = bus_valid_q;
  assign io.o_bus_cmd_op    = bus_op_q;
  assign io.o_bus_cmd_data  = bus_data_q;
  assign io.o_outstanding   = count_q;
  assign io.o_orphan        = orphan_q;

  always_comb begin
    bus_valid_d  = bus_valid_q;
    bus_op_d     = bus_op_q;
    bus_data_d   = bus_data_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    orphan_d     = orphan_q | (fifo_empty & io.i_bus_status_valid);
    if (accept) begin
      bus_valid_d  = 1'b1;
      bus_op_d     = sel_op;
      bus_data_d   = sel_data;
      last_grant_d = grant;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
    end else if (io.i_bus_cmd_ready) begin
      bus_valid_d = 1'b0;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= grant;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus_valid_q  <= 1'b0;
      bus_op_q     <= 1'b0;
      bus_data_q   <= '0;
      last_grant_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      bus_valid_q  <= bus_valid_d;
      bus_op_q     <= bus_op_d;
      bus_data_q   <= bus_data_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      orphan_q     <= orphan_d;
    end
  end

`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && io.i_bus_status && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign io.o_error_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_cmd_status_bridge.sv
// Directed and randomized checks of cmd_status_bridge against a queue-based reference model.
// Error-count checks are compiled in when CMD_STATUS_BRIDGE_ERRCNT_EN is defined.
module tb_cmd_status_bridge;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int D  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cmd_status_bridge_if #(.CHANNELS(CH), .CMD_WIDTH(W), .DEPTH(D)) bif ();

  cmd_status_bridge #(.CHANNELS(CH), .CMD_WIDTH(W), .DEPTH(D)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding channel IDs in issue order, plus the bus register contents
  int         m_q[$];
  int         m_last;
  bit         m_bvalid;
  bit         m_bop;
  logic [7:0] m_bdata;
  bit         m_orphan;
  int         m_err;
  int         obs_grants[$];

  bit e_acc;
  int e_g;
  bit e_bsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [CH-1:0] v, input int last);
    for (int i = 1; i <= CH; i++) begin
      int c;
      c = (last + i) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_last   = 0;
    m_bvalid = 0;
    m_bop    = 0;
    m_bdata  = '0;
    m_orphan = 0;
    m_err    = 0;
  endtask

  task automatic drive_idle();
    bif.i_cmd_valid        = '0;
    bif.i_cmd_op           = '0;
    bif.i_cmd_data         = '0;
    bif.i_bus_cmd_ready    = 1'b1;
    bif.i_bus_status_valid = 1'b0;
    bif.i_bus_status       = 1'b0;
    bif.i_status_ready     = '1;
  endtask

  task automatic set_ch(input int k, input bit v, input bit op, input logic [7:0] d);
    bif.i_cmd_valid[k]       = v;
    bif.i_cmd_op[k]          = op;
    bif.i_cmd_data[k*W +: W] = d;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic [CH-1:0] exp_rdy;
    logic [CH-1:0] exp_sv;
    bit slot_free;
    int g;
    @(negedge clk);
    slot_free = !m_bvalid || bif.i_bus_cmd_ready;
    g         = rr_pick(bif.i_cmd_valid, m_last);
    e_acc     = slot_free && (m_q.size() < D) && (g >= 0);
    e_g       = g;
    exp_rdy   = '0;
    if (e_acc) exp_rdy[g] = 1'b1;
    exp_sv = '0;
    if (m_q.size() == 0) begin
      e_bsr = 1;
    end else begin
      e_bsr = bif.i_status_ready[m_q[0]];
      exp_sv[m_q[0]] = bif.i_bus_status_valid;
    end
    for (int k = 0; k < CH; k++) if (bif.o_cmd_ready[k]) obs_grants.push_back(k);
    chk("cmd_ready", bif.o_cmd_ready, exp_rdy);
    chk("bus_valid", bif.o_bus_cmd_valid, m_bvalid);
    chk("bus_op", bif.o_bus_cmd_op, m_bop);
    chk("bus_data", bif.o_bus_cmd_data, m_bdata);
    chk("status_valid", bif.o_status_valid, exp_sv);
    chk("bus_status_ready", bif.o_bus_status_ready, e_bsr);
    chk("outstanding", bif.o_outstanding, m_q.size());
    chk("orphan", bif.o_orphan, m_orphan);
    if (exp_sv != '0) chk("status", bif.o_status, bif.i_bus_status);
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    chk("error_count", bif.o_error_count, m_err);
`endif
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (m_q.size() == 0 && bif.i_bus_status_valid) m_orphan = 1;
      if (m_q.size() > 0 && bif.i_bus_status_valid && e_bsr) begin
        if (bif.i_bus_status && m_err < 16'hFFFF) m_err++;
        void'(m_q.pop_front());
      end
      if (e_acc) begin
        m_q.push_back(e_g);
        m_last   = e_g;
        m_bvalid = 1;
        m_bop    = bif.i_cmd_op[e_g];
        m_bdata  = bif.i_cmd_data[e_g*W +: W];
      end else if (bif.i_bus_cmd_ready) begin
        m_bvalid = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int exp_g[5];
    int exp_route[5];
    bit st_pat[5];
    checks = 0;
    errors = 0;
    drive_idle();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_bus_valid", bif.o_bus_cmd_valid, 0);
    chk("rst_bus_data", bif.o_bus_cmd_data, 0);
    chk("rst_outstanding", bif.o_outstanding, 0);
    chk("rst_orphan", bif.o_orphan, 0);
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    chk("rst_error_count", bif.o_error_count, 0);
`endif
    rst = 1'b0;

    // Single READ on channel 0
    set_ch(0, 1, 1, 8'h5A);
    #1 chk("s1_ready", bif.o_cmd_ready, 4'b0001);
    cycle();
    set_ch(0, 0, 0, 8'h00);
    #1;
    chk("s1_bus_valid", bif.o_bus_cmd_valid, 1);
    chk("s1_bus_op", bif.o_bus_cmd_op, 1);
    chk("s1_bus_data", bif.o_bus_cmd_data, 8'h5A);
    chk("s1_outstanding", bif.o_outstanding, 1);
    cycle();
    bif.i_bus_status_valid = 1'b1;
    bif.i_bus_status       = 1'b0;
    #1;
    chk("s1_status_valid", bif.o_status_valid, 4'b0001);
    chk("s1_status", bif.o_status, 0);
    cycle();
    bif.i_bus_status_valid = 1'b0;
    #1 chk("s1_outstanding_after", bif.o_outstanding, 0);

    // All channels valid after reset: search starts at channel 1
    do_reset();
    obs_grants.delete();
    for (int k = 0; k < CH; k++) set_ch(k, 1, k[0], 8'(8'h10 + k));
    repeat (5) cycle();
    drive_idle();
    exp_g = '{1, 2, 3, 0, 1};
    chk("rr_count", obs_grants.size(), 5);
    for (int i = 0; i < 5 && i < obs_grants.size(); i++) chk("rr_order", obs_grants[i], exp_g[i]);
    exp_route = '{2, 4, 8, 1, 2};
    for (int i = 0; i < 5; i++) begin
      bif.i_bus_status_valid = 1'b1;
      bif.i_bus_status       = i[0];
      #1 chk("route", bif.o_status_valid, exp_route[i]);
      cycle();
    end
    bif.i_bus_status_valid = 1'b0;

    // Fill to DEPTH then release one entry
    do_reset();
    set_ch(2, 1, 0, 8'hA5);
    repeat (D) cycle();
    #1;
    chk("full_outstanding", bif.o_outstanding, D);
    chk("full_ready", bif.o_cmd_ready, 0);
    bif.i_bus_status_valid = 1'b1;
    #1 chk("full_pop_ready", bif.o_cmd_ready, 0);
    cycle();
    bif.i_bus_status_valid = 1'b0;
    #1;
    chk("after_pop_outstanding", bif.o_outstanding, D - 1);
    chk("after_pop_ready", bif.o_cmd_ready, 4'b0100);
    cycle();
    chk("refill_outstanding", bif.o_outstanding, D);

    // Drain, then stall the bus with a command held
    bif.i_cmd_valid        = '0;
    bif.i_bus_status_valid = 1'b1;
    repeat (D) cycle();
    bif.i_bus_status_valid = 1'b0;
    set_ch(1, 1, 0, 8'hC3);
    bif.i_bus_cmd_ready = 1'b0;
    #1 chk("stall_first_ready", bif.o_cmd_ready, 4'b0010);
    cycle();
    set_ch(3, 1, 1, 8'h3C);
    repeat (5) begin
      #1;
      chk("stall_ready", bif.o_cmd_ready, 0);
      chk("stall_valid", bif.o_bus_cmd_valid, 1);
      chk("stall_data", bif.o_bus_cmd_data, 8'hC3);
      cycle();
    end
    bif.i_bus_cmd_ready = 1'b1;
    #1 chk("unstall_ready", bif.o_cmd_ready, 4'b1000);
    cycle();
    bif.i_cmd_valid = '0;
    #1;
    chk("unstall_op", bif.o_bus_cmd_op, 1);
    chk("unstall_data", bif.o_bus_cmd_data, 8'h3C);

    // Orphan status on empty FIFO
    do_reset();
    bif.i_bus_status_valid = 1'b1;
    #1;
    chk("orphan_bsr", bif.o_bus_status_ready, 1);
    chk("orphan_sv", bif.o_status_valid, 0);
    cycle();
    bif.i_bus_status_valid = 1'b0;
    repeat (3) cycle();
    chk("orphan_sticky", bif.o_orphan, 1);
    do_reset();
    chk("orphan_cleared", bif.o_orphan, 0);

    // Mixed OK/ERROR responses, then reset mid-stream
    for (int k = 0; k < CH; k++) set_ch(k, 1, 0, 8'(k));
    repeat (5) cycle();
    bif.i_cmd_valid = '0;
    st_pat = '{1, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      bif.i_bus_status_valid = 1'b1;
      bif.i_bus_status       = st_pat[i];
      cycle();
    end
    drive_idle();
    #1 chk("err_outstanding", bif.o_outstanding, 0);
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    chk("err_count3", bif.o_error_count, 3);
`endif
    for (int k = 0; k < CH; k++) set_ch(k, 1, 1, 8'hE0);
    repeat (2) cycle();
    do_reset();
    bif.i_cmd_valid = '0;
    #1;
    chk("midrst_outstanding", bif.o_outstanding, 0);
    chk("midrst_bus_valid", bif.o_bus_cmd_valid, 0);
`ifdef CMD_STATUS_BRIDGE_ERRCNT_EN
    chk("midrst_err", bif.o_error_count, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bif.i_cmd_valid        = CH'($urandom);
      bif.i_cmd_op           = CH'($urandom);
      bif.i_cmd_data         = (CH*W)'($urandom);
      bif.i_bus_cmd_ready    = ($urandom_range(9) < 7);
      bif.i_bus_status_valid = ($urandom_range(9) < 4);
      bif.i_bus_status       = 1'($urandom);
      bif.i_status_ready     = CH'($urandom) | CH'($urandom);
      rst                    = ($urandom_range(149) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
